// File: rtl/recip_scheduler.sv
// recip_scheduler: round-robin time-sharing of one fixed-latency reciprocal divider among NREQ requesters (clk48, rst, req/req_denom in; done/result/overrun/busy out; div_start/div_denom/div_recip divider link)
module recip_scheduler #(
  parameter int NREQ    = 2,
  parameter int DEN_W   = 10,
  parameter int RES_W   = 11,
  parameter int DIV_LAT = 16
) (
  input  logic                  clk48,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DEN_W-1:0] req_denom,
  output logic [NREQ-1:0]       done,
  output logic [NREQ*RES_W-1:0] result,
  output logic [NREQ-1:0]       overrun,
  output logic                  busy,
  output logic                  div_start,
  output logic [DEN_W-1:0]      div_denom,
  input  logic [RES_W-1:0]      div_recip
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(DIV_LAT + 1);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE} state_t;
  state_t              state_q, state_d;
  logic [NREQ-1:0]     pending_q, pending_d, overrun_q, overrun_d, done_q, done_d, clr;
  logic [NREQ*RES_W-1:0] result_q, result_d;
  logic [DEN_W-1:0]    denom_q, denom_d, den_n;
  logic [PW-1:0]       sel_q, sel_d, rr_ptr_q, rr_ptr_d, sel_n;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sat_q, sat_d, div_start_q, div_start_d, busy_q, busy_d, found;
  always_comb begin
    found = 1'b0;
    sel_n = '0;
    den_n = '0;
    for (int k = 1; k <= NREQ; k++)
      if (!found && pending_q[PW'((int'(rr_ptr_q) + k) % NREQ)]) begin
        found = 1'b1;
        sel_n = PW'((int'(rr_ptr_q) + k) % NREQ);
      end
    for (int i = 0; i < NREQ; i++)
      if (PW'(i) == sel_n) den_n = req_denom[i*DEN_W +: DEN_W];
  end
  always_comb begin
    state_d     = state_q;
    clr         = '0;
    denom_d     = denom_q;
    sel_d       = sel_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    result_d    = result_q;
    done_d      = '0;
    div_start_d = 1'b0;
    case (state_q)
      S_IDLE: if (found) begin
        sel_d       = sel_n;
        clr[sel_n]  = 1'b1;
        denom_d     = den_n;
        sat_d       = den_n == '0;
        div_start_d = den_n != '0;
        state_d     = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = CW'(DIV_LAT - 1);
        state_d = sat_q ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? S_CAPTURE : S_WAIT;
      end
      default: begin
        for (int i = 0; i < NREQ; i++)
          if (PW'(i) == sel_q) begin
            result_d[i*RES_W +: RES_W] = sat_q ? {RES_W{1'b1}} : div_recip;
            done_d[i] = 1'b1;
          end
        rr_ptr_d = sel_q;
        state_d  = S_IDLE;
      end
    endcase
    pending_d = (pending_q & ~clr) | req;
    overrun_d = overrun_q | (req & pending_q & ~clr);
    busy_d    = state_d != S_IDLE;
  end
  always_ff @(posedge clk48 or posedge rst)
    if (rst) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      overrun_q   <= '0;
      done_q      <= '0;
      result_q    <= '0;
      denom_q     <= '0;
      sel_q       <= '0;
      rr_ptr_q    <= PW'(NREQ - 1);
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      div_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
      result_q    <= result_d;
      denom_q     <= denom_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      div_start_q <= div_start_d;
      busy_q      <= busy_d;
    end
  assign done      = done_q;
  assign result    = result_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
  assign div_start = div_start_q;
  assign div_denom = denom_q;
endmodule

// File: tb/tb_recip_scheduler.sv
// tb_recip_scheduler: vector table, corner sequences and randomized scoreboard for recip_scheduler
module tb_recip_scheduler;
  localparam int DIV_LAT = 16;
  logic        clk48 = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [19:0] req_denom = '0;
  logic [1:0]  done, overrun;
  logic [21:0] result;
  logic        busy, div_start;
  logic [9:0]  div_denom;
  logic [10:0] div_recip = '0;
  logic [DIV_LAT-1:0] pv = '0;
  logic [10:0] pd [DIV_LAT];
  int passed = 0, total = 0;
  typedef struct {
    logic [1:0]  rq;
    logic [9:0]  d0;
    logic [9:0]  d1;
    logic [1:0]  dn;
    logic [10:0] r0;
    logic [10:0] r1;
    int          lat;
    int          sn;
  } vec_t;
  vec_t tbl [6];
  recip_scheduler #(.NREQ(2), .DEN_W(10), .RES_W(11), .DIV_LAT(DIV_LAT)) dut (
    .clk48(clk48), .rst(rst), .req(req), .req_denom(req_denom), .done(done), .result(result),
    .overrun(overrun), .busy(busy), .div_start(div_start), .div_denom(div_denom), .div_recip(div_recip)
  );
  always #5 clk48 = ~clk48;
  function automatic logic [10:0] recip_of(input logic [9:0] d);
    int q;
    if (d == 0) return 11'd2047;
    q = 65536 / int'(d);
    return (q > 2047) ? 11'd2047 : 11'(q);
  endfunction
  // divider stand-in: answer is valid for exactly one cycle, DIV_LAT cycles after the start pulse
  always @(posedge clk48) begin
    pv <= {pv[DIV_LAT-2:0], div_start};
    pd[0] <= recip_of(div_denom);
    for (int k = 1; k < DIV_LAT; k++) pd[k] <= pd[k-1];
    div_recip <= pv[DIV_LAT-1] ? pd[DIV_LAT-1] : 11'd0;
  end
  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic step();
    @(posedge clk48);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic run_req(input logic [1:0] r, input int budget, output int n, output logic [1:0] d,
                         output int sn, output logic [9:0] sd);
    req = r;
    n = 0;
    d = '0;
    sn = -1;
    sd = '0;
    while (n < budget) begin
      step();
      n++;
      req = '0;
      if (sn < 0 && div_start) begin
        sn = n;
        sd = div_denom;
      end
      if (done != 0) begin
        d = done;
        break;
      end
    end
  endtask
  task automatic count_dones(input int cyc, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < cyc; i++) begin
      step();
      if (done == 2'b01) c0++;
      if (done == 2'b10) c1++;
    end
  endtask
  initial begin
    int n, sn, c0, c1, n2;
    logic [1:0] d;
    logic [9:0] sd;
    int since [2];
    int exp_t, exp_id, free_at, last, id;
    logic [10:0] exp_v;
    logic [10:0] mres [2];
    logic [9:0] mden [2];
    bit outst [2];
    logic [1:0] ed;
    tbl[0] = '{2'b01, 10'd64,   10'd0,   2'b01, 11'd1024, 11'd0,    20, 2};
    tbl[1] = '{2'b10, 10'd64,   10'd0,   2'b10, 11'd1024, 11'd2047, 4,  -1};
    tbl[2] = '{2'b10, 10'd64,   10'd500, 2'b10, 11'd1024, 11'd131,  20, 2};
    tbl[3] = '{2'b01, 10'd1023, 10'd500, 2'b01, 11'd64,   11'd131,  20, 2};
    tbl[4] = '{2'b10, 10'd1023, 10'd1,   2'b10, 11'd64,   11'd2047, 20, 2};
    tbl[5] = '{2'b01, 10'd33,   10'd1,   2'b01, 11'd1985, 11'd2047, 20, 2};
    do_reset();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    for (int v = 0; v < 6; v++) begin
      req_denom = {tbl[v].d1, tbl[v].d0};
      run_req(tbl[v].rq, 60, n, d, sn, sd);
      chk($sformatf("vec%0d_latency", v), n, tbl[v].lat);
      chk($sformatf("vec%0d_done", v), d, tbl[v].dn);
      chk($sformatf("vec%0d_result", v), result, {tbl[v].r1, tbl[v].r0});
      chk($sformatf("vec%0d_start_cycle", v), sn, tbl[v].sn);
      if (tbl[v].sn >= 0) chk($sformatf("vec%0d_div_denom", v), sd, tbl[v].rq[0] ? tbl[v].d0 : tbl[v].d1);
      chk($sformatf("vec%0d_busy", v), busy, 0);
      step();
      chk($sformatf("vec%0d_done_pulse", v), done, 0);
    end
    chk("overrun_after_table", overrun, 0);
    req_denom = {10'd0, 10'd64};
    req = 2'b01;
    step();
    req = '0;
    repeat (9) step();
    chk("mid_wait_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_overrun", overrun, 0);
    chk("async_rst_div_start", div_start, 0);
    step();
    step();
    rst = 1'b0;
    count_dones(40, c0, c1);
    chk("post_rst_no_done", c0 + c1, 0);
    req_denom = {10'd0, 10'd100};
    run_req(2'b01, 60, n, d, sn, sd);
    chk("post_rst_latency", n, 20);
    chk("post_rst_done", d, 2'b01);
    chk("post_rst_result", result, {11'd0, 11'd655});
    do_reset();
    req_denom = {10'd200, 10'd100};
    run_req(2'b11, 60, n, d, sn, sd);
    chk("both_first_latency", n, 20);
    chk("both_first_done", d, 2'b01);
    chk("both_first_result0", result[10:0], 655);
    run_req(2'b00, 60, n2, d, sn, sd);
    chk("both_second_gap", n2, 19);
    chk("both_second_done", d, 2'b10);
    chk("both_second_result", result, {11'd327, 11'd655});
    req_denom = {10'd200, 10'd64};
    req = 2'b10;
    step();
    req = 2'b01;
    step();
    req = '0;
    step();
    step();
    req = 2'b01;
    step();
    req = '0;
    chk("overrun_set", overrun, 2'b01);
    count_dones(70, c0, c1);
    chk("overrun_done0_count", c0, 1);
    chk("overrun_done1_count", c1, 1);
    chk("overrun_sticky", overrun, 2'b01);
    do_reset();
    chk("overrun_cleared", overrun, 0);
    req = 2'b01;
    step();
    req = 2'b01;
    step();
    req = '0;
    count_dones(60, c0, c1);
    chk("setwins_done0_count", c0, 2);
    chk("setwins_overrun", overrun, 0);
    do_reset();
    since[0] = -1;
    since[1] = -1;
    exp_t = -1;
    exp_id = 0;
    exp_v = '0;
    mres[0] = '0;
    mres[1] = '0;
    mden[0] = '0;
    mden[1] = '0;
    outst[0] = 0;
    outst[1] = 0;
    free_at = 0;
    last = 1;
    for (int c = 0; c < 800; c++) begin
      ed = '0;
      if (exp_t == c) begin
        ed[exp_id] = 1'b1;
        mres[exp_id] = exp_v;
        outst[exp_id] = 0;
        exp_t = -1;
      end
      if (ed != 0 || done != 0) begin
        chk($sformatf("rand_done_c%0d", c), done, ed);
        if (ed != 0) chk($sformatf("rand_result_c%0d", c), result, {mres[1], mres[0]});
      end
      if (c >= free_at)
        for (int k = 1; k <= 2; k++) begin
          id = (last + k) % 2;
          if (since[id] >= 0 && since[id] <= c) begin
            free_at = c + ((mden[id] == 0) ? 3 : DIV_LAT + 3);
            exp_t = free_at;
            exp_id = id;
            exp_v = recip_of(mden[id]);
            last = id;
            since[id] = -1;
            break;
          end
        end
      for (int i = 0; i < 2; i++)
        if (!outst[i] && $urandom_range(0, 5) == 0) begin
          case ($urandom_range(0, 3))
            0: mden[i] = 10'd0;
            1: mden[i] = 10'($urandom_range(1, 40));
            default: mden[i] = 10'($urandom_range(1, 1023));
          endcase
          req[i] = 1'b1;
          req_denom[i*10 +: 10] = mden[i];
          outst[i] = 1;
          since[i] = c + 1;
        end
      step();
      req = '0;
    end
    chk("rand_overrun", overrun, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
